// File: rtl/ks_pkg.sv
// ks_pkg: shared widths, latency, tag and response types for the shared adder arbiter
package ks_pkg;
    localparam int KS_W         = 25;
    localparam int KS_LAT       = 6;
    localparam int KS_RSP_DEPTH = 4;
    typedef enum logic {TAG_MAC = 1'b0, TAG_ADD = 1'b1} tag_t;
    typedef struct packed {
        logic [KS_W-1:0] sum;
        logic            cout;
        logic            sign;
    } rsp_t;
endpackage

// File: rtl/ks_add_arbiter_if.sv
// ks_add_arbiter_if: request, adder and response bundles of the shared adder arbiter
interface ks_req_if #(parameter int W = ks_pkg::KS_W);
    logic         valid;
    logic         ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sign;
    modport master (output valid, a, b, sign, input ready);
    modport slave  (input valid, a, b, sign, output ready);
endinterface

interface ks_add_if #(parameter int W = ks_pkg::KS_W);
    logic         issue_valid;
    logic [W-1:0] issue_a;
    logic [W-1:0] issue_b;
    logic         issue_sign;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic         add_sign;
    modport master (output issue_valid, issue_a, issue_b, issue_sign, input add_sum, add_cout, add_sign);
    modport slave  (input issue_valid, issue_a, issue_b, issue_sign, output add_sum, add_cout, add_sign);
endinterface

interface ks_rsp_if #(parameter int W = ks_pkg::KS_W);
    logic         valid;
    logic         ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         sign;
    modport master (output valid, sum, cout, sign, input ready);
    modport slave  (input valid, sum, cout, sign, output ready);
endinterface

// File: rtl/ks_rsp_fifo.sv
// ks_rsp_fifo: synchronous response FIFO with wrap-bit pointers and async active-low reset
module ks_rsp_fifo
    import ks_pkg::*;
#(
    parameter int DEPTH = KS_RSP_DEPTH
) (
    input  logic clock,
    input  logic resetn,
    input  logic wr_i,
    input  rsp_t wdata_i,
    input  logic rd_i,
    output rsp_t rdata_o,
    output logic valid_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wp_q, wp_d, rp_q, rp_d;
    rsp_t        mem_q [DEPTH];
    logic        empty, full;

    // Status flags, head data and pointer advance; popping an empty FIFO is ignored
    always_comb begin
        empty   = wp_q == rp_q;
        full    = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
        valid_o = ~empty;
        rdata_o = mem_q[rp_q[PW-1:0]];
        wp_d    = wp_q + (PW+1)'(wr_i);
        rp_d    = rp_q + (PW+1)'(rd_i & ~empty);
    end

    // Pointer registers
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end

    // Storage needs no reset: contents are only visible through the pointers
    always_ff @(posedge clock)
        if (wr_i) mem_q[wp_q[PW-1:0]] <= wdata_i;

    // Credits upstream guarantee a write never finds the FIFO full
    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn) !(wr_i && full));
endmodule

// File: rtl/ks_add_arbiter.sv
// ks_add_arbiter: round-robin, credit-gated sharing of one fixed-latency adder between two requesters
module ks_add_arbiter
    import ks_pkg::*;
#(
    parameter int W         = KS_W,
    parameter int LAT       = KS_LAT,
    parameter int RSP_DEPTH = KS_RSP_DEPTH
) (
    input  logic      clock,
    input  logic      resetn,
    ks_req_if.slave   req0,
    ks_req_if.slave   req1,
    ks_add_if.master  add,
    ks_rsp_if.master  rsp0,
    ks_rsp_if.master  rsp1,
    output logic      busy
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic          rr_q, rr_d;
    logic [1:0]    elig, grant, pop, wr;
    logic          issue_valid_q, issue_sign_q;
    logic [W-1:0]  issue_a_q, issue_b_q;
    tag_t          issue_tag_q;
    logic [LAT-1:0] pipe_vld_q;
    tag_t          pipe_tag_q [LAT];
    rsp_t          wdata;
    rsp_t          rdata [2];

    // Eligibility, round-robin grant and credit bookkeeping
    always_comb begin
        elig[0]    = req0.valid & (credit_q[0] != '0);
        elig[1]    = req1.valid & (credit_q[1] != '0);
        grant[0]   = elig[0] & (~elig[1] | ~rr_q);
        grant[1]   = elig[1] & (~elig[0] | rr_q);
        req0.ready = grant[0] & resetn;
        req1.ready = grant[1] & resetn;
        rr_d       = grant[0] ? 1'b1 : grant[1] ? 1'b0 : rr_q;
        pop[0]     = rsp0.valid & rsp0.ready;
        pop[1]     = rsp1.valid & rsp1.ready;
        for (int k = 0; k < 2; k++) credit_d[k] = credit_q[k] + CW'(pop[k]) - CW'(grant[k]);
    end

    // Round-robin pointer and per-requester credits
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            rr_q        <= 1'b0;
            credit_q[0] <= CW'(RSP_DEPTH);
            credit_q[1] <= CW'(RSP_DEPTH);
        end else begin
            rr_q     <= rr_d;
            credit_q <= credit_d;
        end

    // Registered issue to the adder; data is held when nothing is granted
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            issue_valid_q <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_sign_q  <= 1'b0;
            issue_tag_q   <= TAG_MAC;
        end else begin
            issue_valid_q <= |grant;
            if (|grant) begin
                issue_a_q    <= grant[1] ? req1.a : req0.a;
                issue_b_q    <= grant[1] ? req1.b : req0.b;
                issue_sign_q <= grant[1] ? req1.sign : req0.sign;
                issue_tag_q  <= grant[1] ? TAG_ADD : TAG_MAC;
            end
        end

    // Tag pipe mirrors the adder latency so the last stage lines up with add_sum
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) pipe_tag_q[i] <= TAG_MAC;
        end else begin
            pipe_vld_q[0] <= issue_valid_q;
            pipe_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end

    // Route the adder result to the FIFO of its requester and expose the heads
    always_comb begin
        wdata      = '{sum: add.add_sum, cout: add.add_cout, sign: add.add_sign};
        wr[0]      = pipe_vld_q[LAT-1] & (pipe_tag_q[LAT-1] == TAG_MAC);
        wr[1]      = pipe_vld_q[LAT-1] & (pipe_tag_q[LAT-1] == TAG_ADD);
        rsp0.sum   = rdata[0].sum;
        rsp0.cout  = rdata[0].cout;
        rsp0.sign  = rdata[0].sign;
        rsp1.sum   = rdata[1].sum;
        rsp1.cout  = rdata[1].cout;
        rsp1.sign  = rdata[1].sign;
        busy       = issue_valid_q | (|pipe_vld_q) | rsp0.valid | rsp1.valid;
    end

    assign add.issue_valid = issue_valid_q;
    assign add.issue_a     = issue_a_q;
    assign add.issue_b     = issue_b_q;
    assign add.issue_sign  = issue_sign_q;

    ks_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo0 (
        .clock   (clock),
        .resetn  (resetn),
        .wr_i    (wr[0]),
        .wdata_i (wdata),
        .rd_i    (rsp0.ready),
        .rdata_o (rdata[0]),
        .valid_o (rsp0.valid)
    );

    ks_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo1 (
        .clock   (clock),
        .resetn  (resetn),
        .wr_i    (wr[1]),
        .wdata_i (wdata),
        .rd_i    (rsp1.ready),
        .rdata_o (rdata[1]),
        .valid_o (rsp1.valid)
    );
endmodule

// File: tb/tb_ks_add_arbiter.sv
// tb_ks_add_arbiter: directed self-checking bench with a behavioural pipelined adder
module tb_ks_add_arbiter;
    localparam int W   = 25;
    localparam int LAT = 6;
    localparam int D   = 4;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    int   tests = 0;
    int   fails = 0;

    ks_req_if #(.W(W)) r0 ();
    ks_req_if #(.W(W)) r1 ();
    ks_add_if #(.W(W)) ad ();
    ks_rsp_if #(.W(W)) s0 ();
    ks_rsp_if #(.W(W)) s1 ();

    ks_add_arbiter #(.W(W), .LAT(LAT), .RSP_DEPTH(D)) dut (
        .clock  (clock),
        .resetn (resetn),
        .req0   (r0),
        .req1   (r1),
        .add    (ad),
        .rsp0   (s0),
        .rsp1   (s1),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    logic [W:0] st_s [LAT];
    logic       st_g [LAT];

    // Adder model: {cout,sum} = a + b + sign, LAT stages, shares resetn
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) begin
                st_s[i] <= '0;
                st_g[i] <= 1'b0;
            end
        end else begin
            st_s[0] <= {1'b0, ad.issue_a} + {1'b0, ad.issue_b} + {{W{1'b0}}, ad.issue_sign};
            st_g[0] <= ad.issue_sign;
            for (int i = 1; i < LAT; i++) begin
                st_s[i] <= st_s[i-1];
                st_g[i] <= st_g[i-1];
            end
        end

    assign ad.add_sum  = st_s[LAT-1][W-1:0];
    assign ad.add_cout = st_s[LAT-1][W];
    assign ad.add_sign = st_g[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        r0.valid = 1'b0; r0.a = '0; r0.b = '0; r0.sign = 1'b0;
        r1.valid = 1'b0; r1.a = '0; r1.b = '0; r1.sign = 1'b0;
        s0.ready = 1'b0; s1.ready = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, g0, g1, e0, e1, n0, n1, stale;
        clear_inputs();
        tick();
        tick();
        r0.valid = 1'b1;
        settle();
        chk("rst_ready0", r0.ready, 0);
        chk("rst_rsp0_valid", s0.valid, 0);
        chk("rst_rsp1_valid", s1.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_valid", ad.issue_valid, 0);
        chk("rst_credit0", dut.credit_q[0], D);
        chk("rst_credit1", dut.credit_q[1], D);
        r0.valid = 1'b0;
        resetn = 1'b1;
        tick();

        r0.a = 25'h0000001; r0.b = 25'h0000001; r0.sign = 1'b0; r0.valid = 1'b1;
        settle();
        chk("t1_ready", r0.ready, 1);
        tick();
        r0.valid = 1'b0;
        settle();
        chk("t1_issue_valid", ad.issue_valid, 1);
        chk("t1_issue_a", ad.issue_a, 1);
        chk("t1_credit0", dut.credit_q[0], D - 1);
        chk("t1_busy", busy, 1);
        k = 1;
        while (!s0.valid && k < 20) begin
            tick();
            k++;
        end
        chk("t1_latency", k, LAT + 2);
        chk("t1_sum", s0.sum, 2);
        chk("t1_cout", s0.cout, 0);
        chk("t1_rsp1_idle", s1.valid, 0);
        s0.ready = 1'b1;
        tick();
        s0.ready = 1'b0;
        settle();
        chk("t1_popped", s0.valid, 0);
        chk("t1_credit_back", dut.credit_q[0], D);
        chk("t1_idle", busy, 0);

        do_reset();
        s0.ready = 1'b1; s1.ready = 1'b1;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            r0.valid = 1'b1; r0.a = W'(32'h100 + g0); r0.b = 25'd1;
            r1.valid = 1'b1; r1.a = W'(32'h200 + g1); r1.b = 25'd2;
            settle();
            chk($sformatf("t2_grant0_%0d", i), r0.ready, (i % 2) == 0);
            chk($sformatf("t2_grant1_%0d", i), r1.ready, (i % 2) == 1);
            if (r0.ready) g0++;
            if (r1.ready) g1++;
            tick();
        end
        r0.valid = 1'b0; r1.valid = 1'b0;
        e0 = 0; e1 = 0;
        for (int c = 0; c < 30; c++) begin
            if (s0.valid) begin
                chk($sformatf("t2_sum0_%0d", e0), s0.sum, 32'h100 + e0 + 1);
                e0++;
            end
            if (s1.valid) begin
                chk($sformatf("t2_sum1_%0d", e1), s1.sum, 32'h200 + e1 + 2);
                e1++;
            end
            tick();
        end
        chk("t2_count0", e0, 4);
        chk("t2_count1", e1, 4);

        do_reset();
        s0.ready = 1'b1; s1.ready = 1'b0;
        r0.valid = 1'b1; r1.valid = 1'b1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (r0.ready) n0++;
            if (r1.ready) n1++;
            tick();
        end
        chk("t3_req1_issues", n1, D);
        chk("t3_req0_issues", n0, 14);
        settle();
        chk("t3_req1_blocked", r1.ready, 0);
        chk("t3_credit1_zero", dut.credit_q[1], 0);
        r0.valid = 1'b0; r1.valid = 1'b0;
        s1.ready = 1'b1;
        for (int j = 1; j <= D; j++) begin
            tick();
            chk($sformatf("t3_credit1_%0d", j), dut.credit_q[1], j);
        end
        chk("t3_rsp1_drained", s1.valid, 0);

        do_reset();
        s0.ready = 1'b0;
        r0.valid = 1'b1; r0.a = 25'd7; r0.b = 25'd9;
        tick(); tick(); tick();
        r0.valid = 1'b0;
        settle();
        chk("t4_credit_one", dut.credit_q[0], 1);
        repeat (12) tick();
        chk("t4_fifo_held", s0.valid, 1);
        r0.valid = 1'b1; s0.ready = 1'b1;
        settle();
        chk("t4_ready_a", r0.ready, 1);
        tick();
        settle();
        chk("t4_credit_a", dut.credit_q[0], 1);
        chk("t4_ready_b", r0.ready, 1);
        tick();
        settle();
        chk("t4_credit_b", dut.credit_q[0], 1);
        r0.valid = 1'b0;
        repeat (15) tick();
        chk("t4_drained_busy", busy, 0);
        chk("t4_drained_credit", dut.credit_q[0], D);

        do_reset();
        r1.a = 25'h1FFFFFF; r1.b = 25'h1FFFFFF; r1.sign = 1'b1; r1.valid = 1'b1;
        settle();
        chk("t5_ready1", r1.ready, 1);
        tick();
        r1.valid = 1'b0;
        k = 1;
        while (!s1.valid && k < 20) begin
            tick();
            k++;
        end
        chk("t5_latency", k, LAT + 2);
        chk("t5_sum", s1.sum, 32'h1FFFFFF);
        chk("t5_cout", s1.cout, 1);
        chk("t5_sign", s1.sign, 1);
        chk("t5_rsp0_idle", s0.valid, 0);
        s1.ready = 1'b1;
        tick();
        s1.ready = 1'b0;

        do_reset();
        r0.valid = 1'b1; r0.a = 25'd5; r0.b = 25'd5;
        tick(); tick();
        r0.valid = 1'b0;
        repeat (10) tick();
        chk("t6_fifo0_filled", s0.valid, 1);
        r1.valid = 1'b1; r1.a = 25'd3; r1.b = 25'd4;
        tick(); tick(); tick();
        r1.valid = 1'b0;
        settle();
        chk("t6_busy_before", busy, 1);
        resetn = 1'b0;
        #1;
        chk("t6_rsp0_cleared", s0.valid, 0);
        chk("t6_rsp1_cleared", s1.valid, 0);
        chk("t6_busy_cleared", busy, 0);
        tick();
        tick();
        resetn = 1'b1;
        settle();
        chk("t6_credit0", dut.credit_q[0], D);
        chk("t6_credit1", dut.credit_q[1], D);
        s0.ready = 1'b1; s1.ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (s0.valid || s1.valid || busy) stale++;
        end
        chk("t6_no_stale", stale, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
